fpu_issue_ctrl: RTL and testbench

//  Issue/retire controller directly upstream of the FPU top. Accepts one FP op per cycle
//  (encoded op, operands, dest reg), drives the FPU's one-hot opcode/x1/x2, and reserves
//  the shared y result-bus slot so different-latency units never collide.

---
 rtl/fpu_issue_ctrl_pkg.sv | 39 +++
 rtl/fpu_issue_ctrl_if.sv | 15 +
 rtl/fpu_issue_ctrl_slot_sched.sv | 52 +++++
 rtl/fpu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// fpu_pkg: op encoding, unit latencies and op decode helpers shared by the
// FPU issue controller, its request interface and its slot scheduler.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_FADD  = 3'd0,
        OP_FSUB  = 3'd1,
        OP_FMUL  = 3'd2,
        OP_FDIV  = 3'd3,
        OP_FSQRT = 3'd4,
        OP_FTOI  = 3'd5,
        OP_ITOF  = 3'd6,
        OP_FABS  = 3'd7
    } fpu_op_e;

    localparam int LAT_FADD = 3;   // also fsub, fmul, fsqrt
    localparam int LAT_FDIV = 6;
    localparam int LAT_ITOF = 2;
    localparam int LAT_FTOI = 1;   // also fabs
    localparam int TAG_W    = 5;

    // fdiv is the longest-latency unit, so it sizes the reservation window
    localparam int MAX_LAT   = LAT_FDIV;
    localparam int DIV_CNT_W = $clog2(LAT_FDIV);

    function automatic logic [2:0] op_lat(input fpu_op_e op);
        case (op)
            OP_FDIV:          return 3'(LAT_FDIV);
            OP_ITOF:          return 3'(LAT_ITOF);
            OP_FTOI, OP_FABS: return 3'(LAT_FTOI);
            default:          return 3'(LAT_FADD);
        endcase
    endfunction

    function automatic logic [7:0] op_onehot(input fpu_op_e op);
        return 8'b0000_0001 << op;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: valid/ready request channel carrying one FP op
// (opcode, operands, destination tag) into the issue controller.
interface fpu_issue_ctrl_if;
    import fpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    fpu_op_e          in_op;
    logic [TAG_W-1:0] in_rd;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;

    modport master (output in_valid, in_op, in_rd, in_x1, in_x2, input in_ready);
    modport slave  (input in_valid, in_op, in_rd, in_x1, in_x2, output in_ready);
endinterface

// File: rtl/fpu_issue_ctrl_slot_sched.sv
// fpu_slot_sched: result-bus reservation for the FPU issue controller.
// busy[k] set means a result is due k cycles from now; busy[0] is the slot
// being retired this cycle. The tag pipe shifts alongside busy, and div_cnt
// enforces fdiv's non-pipelined issue spacing.
module fpu_slot_sched
    import fpu_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst,
    input  fpu_op_e          req_op,
    input  logic             issue,
    input  logic [TAG_W-1:0] issue_rd,
    output logic             can_issue,
    output logic             slot_busy,
    output logic [TAG_W-1:0] slot_rd
);

    logic [MAX_LAT:0]       busy;
    logic [MAX_LAT:0]       busy_shift;
    logic [TAG_W-1:0]       tag [MAX_LAT:0];
    logic [DIV_CNT_W-1:0]   div_cnt;
    logic [2:0]             lat;

    assign lat        = op_lat(req_op);
    assign busy_shift = {1'b0, busy[MAX_LAT:1]};
    // Look at the window as it will be after this edge's shift
    assign can_issue  = !busy_shift[lat] && !(req_op == OP_FDIV && div_cnt != '0);
    assign slot_busy  = busy[0];
    assign slot_rd    = tag[0];

    // Shift reservations/tags toward slot 0; new issue claims slot L
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            div_cnt <= '0;
            for (int i = 0; i <= MAX_LAT; i++) tag[i] <= '0;
        end else begin
            busy <= busy_shift;
            for (int i = 0; i < MAX_LAT; i++) tag[i] <= tag[i+1];
            tag[MAX_LAT] <= '0;
            if (issue) begin
                busy[lat] <= 1'b1;
                tag[lat]  <= issue_rd;
            end
            if (issue && req_op == OP_FDIV)
                div_cnt <= DIV_CNT_W'(LAT_FDIV - 1);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/retire controller in front of the FPU. Drives the
// one-hot opcode and operands, reserves the shared result slot, and emits a
// tagged writeback when the FPU result returns.
// Optional feature macro: FPU_ISSUE_PERF_EN adds perf_issued/perf_stall.
module fpu_issue_ctrl
    import fpu_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rst,
    fpu_issue_ctrl_if.slave   req,
    output logic [7:0]        opcode,
    output logic [31:0]       x1,
    output logic [31:0]       x2,
    input  logic [31:0]       fpu_y,
    input  logic              fpu_valid,
    input  logic              fpu_ovf,
    input  logic              fpu_unf,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_ovf,
    output logic              wb_unf,
    output logic              proto_err
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stall
`endif
);

    logic             can_issue;
    logic             accept;
    logic             slot_busy;
    logic [TAG_W-1:0] slot_rd;
    logic             retire;

    assign req.in_ready = !rst && can_issue;
    assign accept       = req.in_valid && req.in_ready;
    assign retire       = slot_busy && fpu_valid;

    fpu_slot_sched u_sched (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req_op    (req.in_op),
        .issue     (accept),
        .issue_rd  (req.in_rd),
        .can_issue (can_issue),
        .slot_busy (slot_busy),
        .slot_rd   (slot_rd)
    );

    // Register the FPU command; opcode is a one-cycle pulse per accepted op
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            opcode <= '0;
            x1     <= '0;
            x2     <= '0;
        end else begin
            opcode <= accept ? op_onehot(req.in_op) : 8'h00;
            if (accept) begin
                x1 <= req.in_x1;
                x2 <= req.in_x2;
            end
        end
    end

    // Tagged writeback when a reserved slot sees a result; flag any disagreement
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_ovf    <= 1'b0;
            wb_unf    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                wb_rd   <= slot_rd;
                wb_data <= fpu_y;
                wb_ovf  <= fpu_ovf;
                wb_unf  <= fpu_unf;
            end
            if (slot_busy != fpu_valid) proto_err <= 1'b1;
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    // Free-running counters of accepted ops and stalled request cycles
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept) perf_issued <= perf_issued + 32'd1;
            if (req.in_valid && !req.in_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Testbench for fpu_issue_ctrl: behavioural FPU model on the back side and a
// due-cycle scoreboard of expected writebacks on the front side.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [7:0]  opcode;
    logic [31:0] x1, x2;
    logic [31:0] fpu_y;
    logic        fpu_valid, fpu_ovf, fpu_unf;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf, wb_unf;
    logic        proto_err;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    fpu_issue_ctrl_if req_if ();

    fpu_issue_ctrl dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req       (req_if),
        .opcode    (opcode),
        .x1        (x1),
        .x2        (x2),
        .fpu_y     (fpu_y),
        .fpu_valid (fpu_valid),
        .fpu_ovf   (fpu_ovf),
        .fpu_unf   (fpu_unf),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_ovf    (wb_ovf),
        .wb_unf    (wb_unf),
        .proto_err (proto_err)
`ifdef FPU_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_issued = 0;
    int acc_cyc;
    logic force_valid = 1'b0;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] y;
        logic        ovf;
        logic        unf;
    } ent_t;

    ent_t sb[$];   // expected writebacks, keyed by due cycle
    ent_t fq[$];   // results the FPU model will return

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input int op);
        case (op)
            3:       return 6;
            5, 7:    return 1;
            6:       return 2;
            default: return 3;
        endcase
    endfunction

    // Behavioural FPU result: {unf, ovf, y}
    function automatic logic [33:0] fpu_res(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        if (op == 0 && a == 32'h3F80_0000 && b == 32'h4000_0000)
            y = 32'h4040_0000;
        else
            y = a + b + 32'(op);
        return {y[4], y[3], y};
    endfunction

    always @(posedge sys_clk) cyc <= cyc + 1;

    // FPU model: result appears exactly L cycles after the opcode cycle
    always @(posedge sys_clk) begin
        int idx;
        int op;
        logic [33:0] r;
        ent_t e;
        #1;
        fpu_valid = force_valid;
        fpu_y     = '0;
        fpu_ovf   = 1'b0;
        fpu_unf   = 1'b0;
        idx = -1;
        for (int i = 0; i < fq.size(); i++) if (fq[i].due == cyc) idx = i;
        if (idx >= 0) begin
            fpu_valid = 1'b1;
            fpu_y     = fq[idx].y;
            fpu_ovf   = fq[idx].ovf;
            fpu_unf   = fq[idx].unf;
            fq.delete(idx);
        end
        if (opcode != 8'h00) begin
            op = 0;
            for (int b = 0; b < 8; b++) if (opcode[b]) op = b;
            r = fpu_res(op, x1, x2);
            e.due = cyc + exp_lat(op);
            e.rd  = '0;
            e.y   = r[31:0];
            e.ovf = r[32];
            e.unf = r[33];
            fq.push_back(e);
        end
    end

    // Writeback monitor: compare against the scoreboard entry due this cycle
    always @(negedge sys_clk) begin
        int idx;
        if (!rst) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) if (sb[i].due == cyc) idx = i;
            if (wb_valid || idx >= 0) begin
                check("wb_valid", wb_valid, idx >= 0);
                if (wb_valid && idx >= 0) begin
                    check("wb_rd", wb_rd, sb[idx].rd);
                    check("wb_data", wb_data, sb[idx].y);
                    check("wb_flags", {wb_ovf, wb_unf}, {sb[idx].ovf, sb[idx].unf});
                end
                if (idx >= 0) sb.delete(idx);
            end
        end
    end

    // Offer one op (called just after a negedge); returns one cycle after accept
    task automatic issue(input fpu_op_e op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        int waited;
        logic [33:0] r;
        ent_t e;
        waited = 0;
        req_if.in_valid = 1'b1;
        req_if.in_op    = op;
        req_if.in_rd    = rd;
        req_if.in_x1    = a;
        req_if.in_x2    = b;
        #1;
        while (!req_if.in_ready && waited < 20) begin
            @(negedge sys_clk);
            #1;
            waited++;
        end
        if (!req_if.in_ready) begin
            check("issue_timeout", 32'(waited), 0);
        end else begin
            acc_cyc = cyc;
            n_issued++;
            r = fpu_res(int'(op), a, b);
            e.due = cyc + 2 + exp_lat(int'(op));
            e.rd  = rd;
            e.y   = r[31:0];
            e.ovf = r[32];
            e.unf = r[33];
            sb.push_back(e);
        end
        @(negedge sys_clk);
        req_if.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a0, a1;
        rst = 1'b1;
        req_if.in_valid = 1'b0;
        req_if.in_op    = OP_FADD;
        req_if.in_rd    = '0;
        req_if.in_x1    = '0;
        req_if.in_x2    = '0;
        idle(3);
        req_if.in_valid = 1'b1;
        #1;
        check("rst_in_ready", req_if.in_ready, 0);
        check("rst_opcode", opcode, 0);
        check("rst_x1", x1, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_proto_err", proto_err, 0);
        req_if.in_valid = 1'b0;
        rst = 1'b0;
        idle(1);

        // single fadd: opcode pulse next cycle, wb four cycles after that
        issue(OP_FADD, 5'd7, 32'h3F80_0000, 32'h4000_0000);
        check("fadd_opcode", opcode, 8'h01);
        check("fadd_x1", x1, 32'h3F80_0000);
        check("fadd_x2", x2, 32'h4000_0000);
        idle(10);

        // fdiv then fadd three cycles later collides on the result slot
        issue(OP_FDIV, 5'd3, 32'h1000_0000, 32'h0000_0003);
        a0 = acc_cyc;
        idle(2);
        issue(OP_FADD, 5'd4, 32'h0000_0100, 32'h0000_0200);
        check("fdiv_fadd_gap", 32'(acc_cyc - a0), 4);
        idle(12);

        // back-to-back fdiv waits out the divider
        issue(OP_FDIV, 5'd10, 32'h0000_0011, 32'h0000_0022);
        a0 = acc_cyc;
        issue(OP_FDIV, 5'd11, 32'h0000_0033, 32'h0000_0044);
        check("fdiv_fdiv_gap", 32'(acc_cyc - a0), 6);
        idle(12);

        // short-latency ops stream at full rate
        issue(OP_FTOI, 5'd20, 32'h0000_0005, 32'h0);
        a0 = acc_cyc;
        issue(OP_FABS, 5'd21, 32'h8000_0009, 32'h0);
        a1 = acc_cyc;
        check("ftoi_fabs_gap", 32'(a1 - a0), 1);
        issue(OP_ITOF, 5'd22, 32'h0000_0018, 32'h0);
        check("fabs_itof_gap", 32'(acc_cyc - a1), 1);
        idle(10);

        // reset mid-flight: in-flight fmul dropped even though the FPU answers
        issue(OP_FMUL, 5'd9, 32'h0000_0077, 32'h0000_0088);
        idle(1);
        rst = 1'b1;
        sb.delete();
        req_if.in_valid = 1'b1;
        #1;
        check("midrst_in_ready", req_if.in_ready, 0);
        check("midrst_opcode", opcode, 0);
        check("midrst_wb_valid", wb_valid, 0);
        idle(2);
        rst = 1'b0;
        req_if.in_valid = 1'b0;
        idle(12);

        // clear the sticky flag, then drive a stray fpu_valid
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_issued = 0;
        idle(1);
        check("proto_clear", proto_err, 0);
        force_valid = 1'b1;
        idle(1);
        force_valid = 1'b0;
        idle(2);
        check("proto_set", proto_err, 1);
        idle(5);
        check("proto_sticky", proto_err, 1);

        // normal traffic still flows with the flag set
        issue(OP_FSQRT, 5'd15, 32'h0000_1234, 32'h0000_4321);
        idle(8);
        check("sb_drained", 32'(sb.size()), 0);
`ifdef FPU_ISSUE_PERF_EN
        check("perf_issued", perf_issued, 32'(n_issued));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
